// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-triggered, masked, fixed-priority interrupt controller feeding CP0
module irq_ctrl #(
    parameter int N_IRQ       = 8,
    parameter int CAUSE_W     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_IRQ-1:0]   irq_in,
    input  logic               mask_we,
    input  logic [N_IRQ-1:0]   mask_wdata,
    output logic [N_IRQ-1:0]   mask,
    output logic [N_IRQ-1:0]   pending,
    input  logic               eret,
    output logic               irq_out,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic               busy
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t             state;
    logic [N_IRQ-1:0]   sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0]   hist_q;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   cand;
    logic [N_IRQ-1:0]   grant;
    logic [N_IRQ-1:0]   clr;
    logic [CAUSE_W-1:0] grant_idx;
    logic               dispatch;

    assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign cand     = pending & mask;
    // Two's-complement trick isolates the lowest set candidate bit.
    assign grant    = cand & (~cand + N_IRQ'(1));
    assign dispatch = (state == IDLE) && (cand != '0);
    assign clr      = dispatch ? grant : '0;

    always_comb begin
        grant_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                grant_idx = CAUSE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q    <= '0;
            pending   <= '0;
            mask      <= '0;
            irq_out   <= 1'b0;
            irq_cause <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];

            // A new edge on the bit being dispatched re-arms it.
            pending <= (pending & ~clr) | rise;

            if (mask_we) begin
                mask <= mask_wdata;
            end

            case (state)
                IDLE: begin
                    if (dispatch) begin
                        irq_out   <= 1'b1;
                        irq_cause <= grant_idx;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end else begin
                        irq_out <= 1'b0;
                    end
                end
                WAIT: begin
                    irq_out <= 1'b0;
                    if (eret) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    irq_out <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed plus randomized bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;

    localparam int N  = 8;
    localparam int CW = 3;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_in;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic [N-1:0]  mask;
    logic [N-1:0]  pending;
    logic          eret;
    logic          irq_out;
    logic [CW-1:0] irq_cause;
    logic          busy;

    irq_ctrl #(.N_IRQ(N), .CAUSE_W(CW), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .eret       (eret),
        .irq_out    (irq_out),
        .irq_cause  (irq_cause),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: line samples are remembered as a history, an interrupt is
    // "raised" when the sample seen SS edges ago is high and the one before is low.
    logic [N-1:0] hist [SS+1];
    logic [N-1:0] m_pend, m_mask, m_rise, m_cand;
    bit           m_busy, m_pulse, m_was_busy;
    int           m_cause, m_idx;
    bit           model_en = 0;
    int           pulse_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= SS; i++) hist[i] = '0;
            m_pend = '0; m_mask = '0; m_busy = 0; m_pulse = 0; m_cause = 0;
        end else begin
            m_rise = hist[SS-1] & ~hist[SS];
            for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = irq_in;
            m_cand = m_pend & m_mask;
            m_was_busy = m_busy;
            m_pulse = 0;
            if (!m_was_busy && m_cand != 0) begin
                m_idx = 0;
                while (!m_cand[m_idx]) m_idx++;
                m_pulse = 1;
                m_cause = m_idx;
                m_busy = 1;
                m_pend[m_idx] = 1'b0;
            end else if (m_was_busy && eret) begin
                m_busy = 0;
            end
            m_pend = m_pend | m_rise;
            if (mask_we) m_mask = mask_wdata;
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            check("irq_out", {31'd0, irq_out}, {31'd0, m_pulse});
            check("irq_cause", {29'd0, irq_cause}, m_cause);
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("pending", {24'd0, pending}, {24'd0, m_pend});
            check("mask", {24'd0, mask}, {24'd0, m_mask});
            if (irq_out === 1'b1) pulse_cnt++;
        end
    end

    task automatic tick(input logic [N-1:0] i, input bit mw, input logic [N-1:0] md,
                        input bit e, input bit r);
        irq_in = i; mask_we = mw; mask_wdata = md; eret = e; rst = r;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick('0, 0, '0, 0, 0);
    endtask

    int p0;
    logic [N-1:0] rin;

    initial begin
        irq_in = '0; mask_we = 0; mask_wdata = '0; eret = 0; rst = 1;
        @(negedge clk); #1;

        // Reset then idle
        tick('0, 0, '0, 0, 1);
        tick('0, 0, '0, 0, 1);
        model_en = 1;
        idle(20);
        check("rst_pending", {24'd0, pending}, 32'h0);
        check("rst_mask", {24'd0, mask}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_pulses", pulse_cnt, 0);

        // Single dispatch of line 3
        tick('0, 1, 8'hFF, 0, 0);
        p0 = pulse_cnt;
        tick(8'h08, 0, '0, 0, 0);
        idle(2);
        check("single_pend", {24'd0, pending}, 32'h08);
        idle(1);
        check("single_pulse", {31'd0, irq_out}, 32'h1);
        check("single_cause", {29'd0, irq_cause}, 32'h3);
        check("single_busy", {31'd0, busy}, 32'h1);
        check("single_pend0", {24'd0, pending}, 32'h0);
        idle(3);
        check("single_cnt", pulse_cnt - p0, 1);
        tick('0, 0, '0, 1, 0);

        // Priority and blocking: lines 5 and 2 together
        p0 = pulse_cnt;
        tick(8'h24, 0, '0, 0, 0);
        idle(4);
        check("prio_cause", {29'd0, irq_cause}, 32'h2);
        check("prio_pend", {24'd0, pending}, 32'h20);
        idle(8);
        check("prio_block", pulse_cnt - p0, 1);
        tick('0, 0, '0, 1, 0);
        idle(1);
        check("prio_second", {31'd0, irq_out}, 32'h1);
        check("prio_cause2", {29'd0, irq_cause}, 32'h5);
        tick('0, 0, '0, 1, 0);

        // Masking retains pending, dispatches once unmasked
        tick('0, 1, 8'h00, 0, 0);
        p0 = pulse_cnt;
        tick(8'h02, 0, '0, 0, 0);
        idle(6);
        check("mask_pend", {24'd0, pending}, 32'h02);
        check("mask_nopulse", pulse_cnt - p0, 0);
        tick('0, 1, 8'h02, 0, 0);
        idle(1);
        check("mask_pulse", {31'd0, irq_out}, 32'h1);
        check("mask_cause", {29'd0, irq_cause}, 32'h1);
        tick('0, 0, '0, 1, 0);

        // Level hold produces a single pulse
        tick('0, 1, 8'hFF, 0, 0);
        p0 = pulse_cnt;
        for (int k = 0; k < 50; k++) tick(8'h01, 0, '0, (k == 10), 0);
        idle(5);
        check("level_cnt", pulse_cnt - p0, 1);

        // Reset mid-service abandons the window
        tick(8'h10, 0, '0, 0, 0);
        idle(5);
        check("rstsvc_busy", {31'd0, busy}, 32'h1);
        check("rstsvc_cause", {29'd0, irq_cause}, 32'h4);
        tick('0, 0, '0, 0, 1);
        p0 = pulse_cnt;
        idle(10);
        check("rstsvc_busy0", {31'd0, busy}, 32'h0);
        check("rstsvc_pend", {24'd0, pending}, 32'h0);
        check("rstsvc_nopulse", pulse_cnt - p0, 0);

        // Randomized traffic against the model
        rin = '0;
        for (int k = 0; k < 3000; k++) begin
            rin = rin ^ N'($urandom & $urandom & $urandom);
            tick(rin, ($urandom_range(0, 9) == 0), N'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt request controller directly upstream of the CP0 block. Collects up to N_IRQ asynchronous external interrupt lines, synchronises them, detects rising edges, holds pending requests, applies a software mask, and selects one request by fixed priority.
- Issues a single-cycle request pulse to CP0's interrupt input, exposes the cause index, then blocks further requests until CP0 signals exception return (ERET).
- Ensures CP0 never sees a second interrupt while a handler is still running.

Parameters:
- N_IRQ, 8, number of external interrupt lines (1..32).
- CAUSE_W, 3, width of the cause index (must satisfy 2^CAUSE_W >= N_IRQ).
- SYNC_STAGES, 2, flop stages in each input synchroniser (>= 2).

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous reset, active-high.
- irq_in  in  N_IRQ  asynchronous external interrupt lines, level, active-high.
- mask_we  in  1  mask write strobe (driven from the CP0 write path in EXE).
- mask_wdata  in  N_IRQ  new mask value; bit=1 enables that line.
- mask  out  N_IRQ  current mask register.
- pending  out  N_IRQ  current pending register.
- eret  in  1  ERET executed; ends the service window.
- irq_out  out  1  one-cycle request pulse to CP0's interrupt input.
- irq_cause  out  CAUSE_W  index of the line being serviced; held stable through the service window.
- busy  out  1  high while in the service window.

Behaviour:
- Reset (rst=1 at a clock edge) clears everything: synchroniser flops, edge-detect history, pending, mask, irq_out, irq_cause and busy all go to 0, and the FSM goes to IDLE. A reset during WAIT abandons the service window with no pulse.
- Synchroniser:
  - Each irq_in bit passes through SYNC_STAGES flops to give s[i].
  - A history flop h[i] holds the previous s[i].
  - A rising edge is s[i] & ~h[i]. Level-only highs never re-trigger.
- Pending:
  - A rising edge sets pending[i].
  - pending[i] is cleared only when line i is dispatched.
  - If an edge and a dispatch hit the same bit in the same cycle, the set wins and the bit stays 1.
  - Pending bits set while masked are retained and dispatch once the line is unmasked.
- Mask: written on mask_we at the clock edge. A dispatch in the same cycle uses the old mask.
- Candidates: cand = pending & mask. Priority goes to the lowest set index.
- FSM state IDLE:
  - If cand != 0 at a clock edge, register irq_out=1, irq_cause = lowest index, clear that pending bit, set busy=1, and go to WAIT.
  - Otherwise irq_out=0.
- FSM state WAIT:
  - irq_out=0 from the second WAIT cycle onward, so the pulse is exactly 1 cycle wide.
  - No dispatch occurs; pending bits keep accumulating.
  - eret=1 at an edge sets busy=0 and returns to IDLE. The earliest next dispatch is the following edge.
  - eret while in IDLE is ignored.
- Latency with SYNC_STAGES=2: irq_in first sampled high at edge k gives pending set at edge k+2 and irq_out high for the cycle after edge k+3.
- Simultaneous eret and a new edge: the edge is recorded in pending, and dispatch happens at the edge after the return to IDLE.
- irq_cause keeps its last value after eret until the next dispatch.
- Width rule: irq_cause is zero-extended from the line index. Unused upper index values never appear.

Test Plan:
- Reset then idle: rst high for 2 cycles, irq_in=0 -> pending=0, mask=0, irq_out=0, busy=0 for 20 cycles.
- Single dispatch: mask=8'hFF, pulse irq_in[3] high for 1 cycle at edge k -> pending[3]=1 at k+2; irq_out=1 for exactly the cycle after k+3 with irq_cause=3, busy=1, pending=0.
- Priority and blocking: irq_in[5] and irq_in[2] rise together -> cause=2 dispatched first with pending=8'h20 retained; no second pulse until eret; after eret, cause=5 pulses the next cycle.
- Masking: mask=8'h00, edge on irq_in[1] -> pending=8'h02, no pulse; write mask=8'h02 -> pulse with cause=1 on the cycle after the write edge.
- Level hold: irq_in[0] held high for 50 cycles with eret after the first dispatch -> exactly one pulse in total.
- Reset mid-service: dispatch cause=4, assert rst in WAIT -> busy=0, pending=0, irq_out=0, and no further pulse.
